// File: rtl/hc595_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_pkg
//  Description : Shared types and constants for the 74HC595 chain driver.
//                FSM state encoding, default word width / divider, and the
//                frame-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hc595_pkg;

  // Frame phases: one shcp low/high pair per bit, then an stcp high/low pair.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH_HI = 3'd3,
    ST_LATCH_LO = 3'd4
  } state_e;

  localparam int DATA_W_DEF   = 16;  // two cascaded 595s
  localparam int HALF_DIV_DEF = 2;   // shcp = clk/4

  // Every phase lasts HALF_DIV clk cycles; DATA_W bit pairs plus the latch pair.
  function automatic int frame_cycles(input int data_w, input int half_div);
    return (2 * data_w + 2) * half_div;
  endfunction

  localparam int FRAME_CYCLES_DEF = (2 * DATA_W_DEF + 2) * HALF_DIV_DEF;

endpackage
`default_nettype wire

// File: rtl/hc595_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_tick_gen
//  Description : Phase timebase. Counts clk cycles while enabled and emits a
//                one-cycle tick every HALF_DIV cycles. A synchronous clear
//                parks the counter at zero so the first phase after a clear
//                is a full HALF_DIV cycles long.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                en    - count enable
//                clr   - synchronous clear (wins over en)
//                tick  - high on the last cycle of each HALF_DIV window
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_tick_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hc595_shift_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_shift_driver
//  Description : Continuously refreshes a chain of cascaded 74HC595 shift
//                registers from a parallel word. Each frame shifts the word
//                MSB first on ds/shcp and finishes with one stcp pulse.
//  Ports       : clk   - system clock (rising edge)
//                rst_n - asynchronous active-low reset
//                data  - parallel word, sampled only at frame start
//                en    - refresh enable, frames run back-to-back while high
//                ds    - serial data to SER (registered)
//                shcp  - shift clock to SRCLK (registered)
//                stcp  - storage clock to RCLK (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_shift_driver
  import hc595_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HALF_DIV = HALF_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              en,
  output logic              ds,
  output logic              shcp,
  output logic              stcp
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                ds_q, ds_d;
  logic                shcp_q, shcp_d;
  logic                stcp_q, stcp_d;
  logic                tick;
  logic                in_idle;

  // The divider is held cleared in IDLE so each frame starts on a fresh
  // HALF_DIV window; back-to-back frames keep it running.
  assign in_idle = (state_q == ST_IDLE);

  hc595_tick_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!in_idle),
    .clr   (in_idle),
    .tick  (tick)
  );

  // Next-state, shadow capture and bit counter.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          shadow_d = data;
          bit_d    = BIT_MAX;
          state_d  = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_ONE;
            state_d = ST_SHIFT_LO;
          end else begin
            state_d = ST_LATCH_HI;
          end
        end
      end
      ST_LATCH_HI: begin
        if (tick) state_d = ST_LATCH_LO;
      end
      ST_LATCH_LO: begin
        if (tick) begin
          if (en) begin
            shadow_d = data;
            bit_d    = BIT_MAX;
            state_d  = ST_SHIFT_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pins
  // change on the same edge as the state register and never glitch.
  always_comb begin
    ds_d   = 1'b0;
    shcp_d = 1'b0;
    stcp_d = 1'b0;
    case (state_d)
      ST_SHIFT_LO: ds_d = shadow_d[bit_d];
      ST_SHIFT_HI: begin
        ds_d   = shadow_d[bit_d];
        shcp_d = 1'b1;
      end
      ST_LATCH_HI: stcp_d = 1'b1;
      default: begin
        ds_d   = 1'b0;
        shcp_d = 1'b0;
        stcp_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      ds_q     <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      ds_q     <= ds_d;
      shcp_q   <= shcp_d;
      stcp_q   <= stcp_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;

endmodule
`default_nettype wire

// File: tb/tb_hc595_shift_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc595_shift_driver
//  Description : Self-checking bench. Three driver instances (HALF_DIV 2, 1, 5)
//                each feed a behavioural 74HC595 chain model; latched words,
//                bit counts and pulse timing are compared with expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_shift_driver;

  localparam int DW          = 16;
  localparam int LATCH_BOUND = 600;

  logic        clk;
  logic        rst_n, rst_aux_n;
  logic [15:0] data, data_aux;
  logic        en, en_aux;
  logic        ds0, shcp0, stcp0;
  logic        ds1, shcp1, stcp1;
  logic        ds2, shcp2, stcp2;

  int total;
  int bad;
  int cyc;

  hc595_shift_driver #(.DATA_W(16), .HALF_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en),
    .ds(ds0), .shcp(shcp0), .stcp(stcp0)
  );
  hc595_shift_driver #(.DATA_W(16), .HALF_DIV(1)) dut_hd1 (
    .clk(clk), .rst_n(rst_aux_n), .data(data_aux), .en(en_aux),
    .ds(ds1), .shcp(shcp1), .stcp(stcp1)
  );
  hc595_shift_driver #(.DATA_W(16), .HALF_DIV(5)) dut_hd5 (
    .clk(clk), .rst_n(rst_aux_n), .data(data_aux), .en(en_aux),
    .ds(ds2), .shcp(shcp2), .stcp(stcp2)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic int hd_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int frame_of(input int k);
    case (k)
      0: return 68;
      1: return 34;
      default: return 170;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- 595 chain model + pin timing monitor -------------------
  logic        m_ds[3], m_shcp[3], m_stcp[3], m_rstn[3];
  logic [15:0] sr[3];
  logic [15:0] latched[3];
  logic        p_shcp[3], p_stcp[3], p_ds[3];
  int          nbits[3], stcp_w[3], last_shcp[3];
  int          last_stcp[3], prev_stcp[3], latch_cnt[3];

  assign m_ds[0] = ds0;  assign m_shcp[0] = shcp0; assign m_stcp[0] = stcp0; assign m_rstn[0] = rst_n;
  assign m_ds[1] = ds1;  assign m_shcp[1] = shcp1; assign m_stcp[1] = stcp1; assign m_rstn[1] = rst_aux_n;
  assign m_ds[2] = ds2;  assign m_shcp[2] = shcp2; assign m_stcp[2] = stcp2; assign m_rstn[2] = rst_aux_n;

  initial begin
    for (int k = 0; k < 3; k++) begin
      sr[k] = '0; latched[k] = '0; p_shcp[k] = 0; p_stcp[k] = 0; p_ds[k] = 0;
      nbits[k] = 0; stcp_w[k] = 0; last_shcp[k] = 0;
      last_stcp[k] = 0; prev_stcp[k] = 0; latch_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!m_rstn[k]) begin
          // The physical shift register keeps partial bits, but a full frame
          // overwrites all of them, so only the bit tally is restarted.
          nbits[k] = 0; p_shcp[k] = 0; p_stcp[k] = 0; p_ds[k] = 0; stcp_w[k] = 0;
        end else begin
          chk($sformatf("overlap%0d", k), longint'(m_shcp[k] & m_stcp[k]), 0);
          if (m_shcp[k] && !p_shcp[k]) begin
            chk($sformatf("ds_setup%0d", k), longint'(m_ds[k]), longint'(p_ds[k]));
            if (nbits[k] > 0)
              chk($sformatf("shcp_period%0d", k), cyc - last_shcp[k], 2 * hd_of(k));
            last_shcp[k] = cyc;
            sr[k] = {sr[k][14:0], m_ds[k]};
            nbits[k]++;
          end else if (m_shcp[k] && p_shcp[k]) begin
            chk($sformatf("ds_hold%0d", k), longint'(m_ds[k]), longint'(p_ds[k]));
          end
          if (m_stcp[k] && !p_stcp[k]) begin
            chk($sformatf("bits_per_frame%0d", k), nbits[k], DW);
            nbits[k]     = 0;
            latched[k]   = sr[k];
            latch_cnt[k] = latch_cnt[k] + 1;
            prev_stcp[k] = last_stcp[k];
            last_stcp[k] = cyc;
            stcp_w[k]    = 0;
          end
          if (m_stcp[k]) stcp_w[k]++;
          else if (p_stcp[k]) chk($sformatf("stcp_width%0d", k), stcp_w[k], hd_of(k));
          p_shcp[k] = m_shcp[k];
          p_stcp[k] = m_stcp[k];
          p_ds[k]   = m_ds[k];
        end
      end
    end
  end

  // Waits for the next latch pulse of instance k and returns the model output.
  task automatic wait_latch(input int k, output logic [15:0] v);
    int c0;
    bit got;
    c0  = latch_cnt[k];
    got = 1'b0;
    for (int i = 0; i < LATCH_BOUND; i++) begin
      @(negedge clk);
      #1;
      if (latch_cnt[k] != c0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL latch_timeout%0d: got no stcp in %0d cycles, required one", k, LATCH_BOUND);
    end
    v = latched[k];
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] exp_word;
    logic        exp_qa;
    logic        exp_qh;
  } vec_t;

  task automatic main_seq();
    logic [15:0] v, v1, w, prev_w, lv;
    vec_t        tbl[6];
    int          c0, viol;
    bit          got;

    // First frames after reset, then steady-state period.
    wait_latch(0, v); chk("first_frame", v, 16'h1234);
    wait_latch(0, v); chk("second_frame", v, 16'h1234);
    chk("frame_period", last_stcp[0] - prev_stcp[0], frame_of(0));

    // Mid-frame data change is deferred to the next frame.
    repeat (20) @(negedge clk);
    data = 16'h8765;
    wait_latch(0, v); chk("inflight_keeps_old", v, 16'h1234);
    wait_latch(0, v); chk("next_frame_new", v, 16'h8765);

    // Table-driven words.
    tbl[0] = '{16'h0001, 16'h0001, 1'b1, 1'b0};
    tbl[1] = '{16'h8000, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'hAAAA, 16'hAAAA, 1'b0, 1'b1};
    tbl[3] = '{16'h5555, 16'h5555, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      data = tbl[i].d;
      wait_latch(0, v);
      wait_latch(0, v);
      chk($sformatf("tbl_word%0d", i), v, tbl[i].exp_word);
      chk($sformatf("tbl_qa%0d", i), longint'(v[0]), longint'(tbl[i].exp_qa));
      chk($sformatf("tbl_qh%0d", i), longint'(v[15]), longint'(tbl[i].exp_qh));
    end

    // Random words applied at random points in the frame: the first latch
    // after a change shows either the old or the new word, never a mix.
    prev_w = data;
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 67)) @(negedge clk);
      data = w;
      wait_latch(0, v1);
      chk($sformatf("rand_no_tear%0d", i), longint'((v1 == w) || (v1 == prev_w)), 1);
      wait_latch(0, v);
      chk($sformatf("rand_word%0d", i), v, w);
      prev_w = w;
    end
    chk("frame_period_late", last_stcp[0] - prev_stcp[0], frame_of(0));

    // Enable drop: current frame completes, then the pins go quiet.
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_latch(0, v); chk("en_drop_completes", v, prev_w);
    repeat (6) @(negedge clk);
    c0   = latch_cnt[0];
    viol = 0;
    repeat (150) begin
      @(negedge clk);
      #1;
      if (ds0 || shcp0 || stcp0) viol++;
    end
    chk("idle_quiet", viol, 0);
    chk("idle_no_latch", latch_cnt[0] - c0, 0);
    data = 16'hA5C3;
    en   = 1'b1;
    wait_latch(0, v); chk("restart_frame", v, 16'hA5C3);

    // Reset while shcp is high: pins drop at once, no latch is issued.
    repeat (10) @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (shcp0) begin
        got = 1'b1;
        break;
      end
    end
    chk("saw_shift_hi", longint'(got), 1);
    c0 = latch_cnt[0];
    lv = latched[0];
    rst_n = 1'b0;
    #1;
    chk("rst_ds", longint'(ds0), 0);
    chk("rst_shcp", longint'(shcp0), 0);
    chk("rst_stcp", longint'(stcp0), 0);
    data = 16'h3C0F;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_no_latch", latch_cnt[0] - c0, 0);
    chk("rst_keeps_latched", latched[0], lv);
    wait_latch(0, v); chk("post_reset_frame", v, 16'h3C0F);
  endtask

  task automatic aux_seq();
    logic [15:0] v, pat;
    for (int p = 0; p < 2; p++) begin
      pat      = (p == 0) ? 16'hFFFF : 16'h0000;
      data_aux = pat;
      for (int k = 1; k < 3; k++) begin
        wait_latch(k, v);
        wait_latch(k, v);
        chk($sformatf("aux_word%0d_%0d", k, p), v, pat);
        chk($sformatf("aux_period%0d_%0d", k, p), last_stcp[k] - prev_stcp[k], frame_of(k));
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    rst_aux_n = 1'b0;
    data      = 16'h1234;
    en        = 1'b1;
    data_aux  = 16'hFFFF;
    en_aux    = 1'b1;
    #145;
    chk("reset_ds", longint'(ds0), 0);
    chk("reset_shcp", longint'(shcp0), 0);
    chk("reset_stcp", longint'(stcp0), 0);
    chk("reset_aux", longint'({ds1, shcp1, stcp1, ds2, shcp2, stcp2}), 0);
    #55;
    rst_n     = 1'b1;
    rst_aux_n = 1'b1;
    fork
      main_seq();
      aux_seq();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by t=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
